// File: rtl/ex_operand_stage_pkg.sv
// Shared constants, ALU control codes and the ID/EX payload type for the operand stage.
// Extends the ALU code set used by the EX units.
package ex_operand_stage_pkg;

    localparam int XLEN = 32;
    localparam int CW   = 5;
    localparam int RW   = 5;
    localparam int SHW  = 5;

    localparam logic [RW-1:0] X0 = '0;

    typedef enum logic [CW-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_ISLL = 5'd10,
        ALU_ISRL = 5'd11,
        ALU_ISRA = 5'd12,
        ALU_LUI  = 5'd13
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [CW-1:0]   alu_c;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            we;
        logic            is_load;
    } idex_t;

    // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
    function automatic logic load_use(input logic id_valid, input logic ex_valid,
                                      input logic ex_is_load, input logic [RW-1:0] ex_rd,
                                      input logic [RW-1:0] id_rs1, input logic [RW-1:0] id_rs2);
        return id_valid & ex_valid & ex_is_load & (ex_rd != X0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID, forwarding and EX-side signals of the ID/EX operand stage.
// master = the surrounding pipeline, slave = the operand stage itself.
interface ex_operand_stage_if;
    import ex_operand_stage_pkg::*;

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [CW-1:0]   id_alu_c;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic [RW-1:0]   id_rd;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic            id_we;
    logic            id_is_load;
    logic            flush;

    logic [RW-1:0]   mem_rd;
    logic            mem_we;
    logic [XLEN-1:0] mem_val;
    logic [RW-1:0]   wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_val;

    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [CW-1:0]   ex_alu_c;
    logic [RW-1:0]   ex_rd;
    logic            ex_we;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [SHW-1:0]  ex_shamt;
    logic [XLEN-1:0] ex_store_val;
    logic [31:0]     bubble_cnt;

    modport master (
        output id_valid, id_pc, id_alu_c, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
               id_imm, id_use_imm, id_we, id_is_load, flush,
               mem_rd, mem_we, mem_val, wb_rd, wb_we, wb_val,
        input  stall, ex_valid, ex_pc, ex_alu_c, ex_rd, ex_we, ex_is_load,
               ex_a, ex_b, ex_shamt, ex_store_val, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_alu_c, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
               id_imm, id_use_imm, id_we, id_is_load, flush,
               mem_rd, mem_we, mem_val, wb_rd, wb_we, wb_val,
        output stall, ex_valid, ex_pc, ex_alu_c, ex_rd, ex_we, ex_is_load,
               ex_a, ex_b, ex_shamt, ex_store_val, bubble_cnt
    );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Single-operand forwarding priority mux: x0 -> 0, then EX/MEM, then MEM/WB, then register file.
module ex_operand_stage_fwd_mux
    import ex_operand_stage_pkg::*;
(
    input  logic [RW-1:0]   i_rs,
    input  logic [XLEN-1:0] i_rf,
    input  logic            i_mem_we,
    input  logic [RW-1:0]   i_mem_rd,
    input  logic [XLEN-1:0] i_mem_val,
    input  logic            i_wb_we,
    input  logic [RW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_val,
    output logic [XLEN-1:0] o_val
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_we & (i_mem_rd == i_rs);
    assign w_wb_hit  = i_wb_we  & (i_wb_rd  == i_rs);

    always_comb begin
        o_val = i_rf;
        if (i_rs == X0)
            o_val = '0;
        else if (w_mem_hit)
            o_val = i_mem_val;
        else if (w_wb_hit)
            o_val = i_wb_val;
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: latches decoded fields, inserts load-use bubbles, honours flush,
// and presents forwarded ALU/shifter operands to EX with no added latency.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ex_operand_stage_if.slave bus
);

    idex_t           r_ex;
    logic [31:0]     r_bubble_cnt;
    idex_t           w_id;
    logic            w_hz;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_b;

    always_comb begin
        w_id         = '0;
        w_id.valid   = bus.id_valid;
        w_id.pc      = bus.id_pc;
        w_id.alu_c   = bus.id_alu_c;
        w_id.rs1     = bus.id_rs1;
        w_id.rs2     = bus.id_rs2;
        w_id.rd      = bus.id_rd;
        w_id.rs1_val = bus.id_rs1_val;
        w_id.rs2_val = bus.id_rs2_val;
        w_id.imm     = bus.id_imm;
        w_id.use_imm = bus.id_use_imm;
        w_id.we      = bus.id_we & bus.id_valid;
        w_id.is_load = bus.id_is_load;
    end

    assign w_hz = load_use(bus.id_valid, r_ex.valid, r_ex.is_load, r_ex.rd,
                           bus.id_rs1, bus.id_rs2);

    // Flush outranks the hazard; a killed slot is not counted as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.flush) begin
            r_ex.valid   <= 1'b0;
            r_ex.we      <= 1'b0;
            r_ex.is_load <= 1'b0;
        end else if (w_hz) begin
            r_ex.valid   <= 1'b0;
            r_ex.we      <= 1'b0;
            r_ex.is_load <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_ex <= w_id;
        end
    end

    ex_operand_stage_fwd_mux u_fwd_rs1 (
        .i_rs      (r_ex.rs1),
        .i_rf      (r_ex.rs1_val),
        .i_mem_we  (bus.mem_we),
        .i_mem_rd  (bus.mem_rd),
        .i_mem_val (bus.mem_val),
        .i_wb_we   (bus.wb_we),
        .i_wb_rd   (bus.wb_rd),
        .i_wb_val  (bus.wb_val),
        .o_val     (w_rs1_fwd)
    );

    ex_operand_stage_fwd_mux u_fwd_rs2 (
        .i_rs      (r_ex.rs2),
        .i_rf      (r_ex.rs2_val),
        .i_mem_we  (bus.mem_we),
        .i_mem_rd  (bus.mem_rd),
        .i_mem_val (bus.mem_val),
        .i_wb_we   (bus.wb_we),
        .i_wb_rd   (bus.wb_rd),
        .i_wb_val  (bus.wb_val),
        .o_val     (w_rs2_fwd)
    );

    assign w_b = r_ex.use_imm ? r_ex.imm : w_rs2_fwd;

    assign bus.stall        = w_hz;
    assign bus.ex_valid     = r_ex.valid;
    assign bus.ex_pc        = r_ex.pc;
    assign bus.ex_alu_c     = r_ex.alu_c;
    assign bus.ex_rd        = r_ex.rd;
    assign bus.ex_we        = r_ex.we;
    assign bus.ex_is_load   = r_ex.is_load;
    assign bus.ex_a         = w_rs1_fwd;
    assign bus.ex_b         = w_b;
    assign bus.ex_shamt     = w_b[SHW-1:0];
    assign bus.ex_store_val = w_rs2_fwd;
    assign bus.bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed plus randomized checks of the ID/EX operand stage against a behavioural model.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural picture of the instruction currently sitting in EX.
    logic        m_valid, m_use_imm, m_we, m_is_load;
    logic [31:0] m_pc, m_rs1v, m_rs2v, m_imm, m_bubbles;
    logic [4:0]  m_alu, m_rs1, m_rs2, m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (bus.mem_we && bus.mem_rd == rs) return bus.mem_val;
        if (bus.wb_we && bus.wb_rd == rs) return bus.wb_val;
        return rf;
    endfunction

    function automatic logic model_hz();
        return bus.id_valid && m_valid && m_is_load && m_rd != 0 &&
               (m_rd == bus.id_rs1 || m_rd == bus.id_rs2);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_use_imm = 0; m_we = 0; m_is_load = 0;
        m_pc = 0; m_rs1v = 0; m_rs2v = 0; m_imm = 0; m_bubbles = 0;
        m_alu = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_alu_c = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rd = 0; bus.id_rs1_val = 0; bus.id_rs2_val = 0; bus.id_imm = 0;
        bus.id_use_imm = 0; bus.id_we = 0; bus.id_is_load = 0; bus.flush = 0;
        bus.mem_rd = 0; bus.mem_we = 0; bus.mem_val = 0;
        bus.wb_rd = 0; bus.wb_we = 0; bus.wb_val = 0;
    endtask

    task automatic set_id(input logic [4:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                          input logic we, input logic ld);
        bus.id_valid = 1; bus.id_pc = bus.id_pc + 32'd4; bus.id_alu_c = alu;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_val = 32'h100 + 32'(rs1); bus.id_rs2_val = 32'h200 + 32'(rs2);
        bus.id_imm = imm; bus.id_use_imm = use_imm; bus.id_we = we; bus.id_is_load = ld;
    endtask

    // Check current outputs against the model, clock once, advance the model.
    task automatic step();
        logic hz;
        #1;
        hz = model_hz();
        chk("stall", 32'(bus.stall), 32'(hz));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_we", 32'(bus.ex_we), 32'(m_we));
        chk("bubble_cnt", bus.bubble_cnt, m_bubbles);
        if (m_valid) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_alu_c", 32'(bus.ex_alu_c), 32'(m_alu));
            chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
            chk("ex_is_load", 32'(bus.ex_is_load), 32'(m_is_load));
            chk("ex_a", bus.ex_a, fwd(m_rs1, m_rs1v));
            chk("ex_store_val", bus.ex_store_val, fwd(m_rs2, m_rs2v));
            chk("ex_b", bus.ex_b, m_use_imm ? m_imm : fwd(m_rs2, m_rs2v));
            chk("ex_shamt", 32'(bus.ex_shamt),
                32'((m_use_imm ? m_imm : fwd(m_rs2, m_rs2v)) % 32));
        end
        @(posedge clk);
        if (rst) model_reset();
        else if (bus.flush || hz) begin
            m_valid = 0; m_we = 0; m_is_load = 0;
            if (!bus.flush) m_bubbles = m_bubbles + 1;
        end else begin
            m_valid = bus.id_valid; m_pc = bus.id_pc; m_alu = bus.id_alu_c;
            m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_rd = bus.id_rd;
            m_rs1v = bus.id_rs1_val; m_rs2v = bus.id_rs2_val; m_imm = bus.id_imm;
            m_use_imm = bus.id_use_imm; m_we = bus.id_we && bus.id_valid;
            m_is_load = bus.id_is_load;
        end
        #1;
    endtask

    initial begin
        logic [31:0] bc;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_bubble", bus.bubble_cnt, 0);
        chk("rst_ex_a", bus.ex_a, 0);
        rst = 0;

        // addi x1,x0,5
        set_id(ALU_ADD, 0, 0, 1, 32'd5, 1, 1, 0);
        step();
        chk("addi_valid", 32'(bus.ex_valid), 1);
        chk("addi_a", bus.ex_a, 0);
        chk("addi_b", bus.ex_b, 5);
        chk("addi_rd", 32'(bus.ex_rd), 1);

        // lw x3 then sll x4,x3,x2
        set_id(ALU_ADD, 1, 0, 3, 32'd8, 1, 1, 1);
        step();
        set_id(ALU_SLL, 3, 2, 4, 32'd0, 0, 1, 0);
        #1 chk("lu_stall", 32'(bus.stall), 1);
        step();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
        chk("lu_bubble_cnt", bus.bubble_cnt, 1);
        step();
        chk("lu_sll_valid", 32'(bus.ex_valid), 1);
        chk("lu_sll_rd", 32'(bus.ex_rd), 4);

        // forwarding priority on rs1=x7
        set_id(ALU_ADD, 7, 0, 8, 32'd0, 0, 1, 0);
        step();
        bus.id_valid = 0;
        bus.mem_we = 1; bus.mem_rd = 7; bus.mem_val = 32'hAAAA0000;
        bus.wb_we = 1; bus.wb_rd = 7; bus.wb_val = 32'h1234;
        #1 chk("fwd_mem", bus.ex_a, 32'hAAAA0000);
        bus.mem_we = 0;
        #1 chk("fwd_wb", bus.ex_a, 32'h1234);
        bus.wb_we = 0;
        step();

        // srai with rs2=x0 while MEM writes x0
        set_id(ALU_ISRA, 5, 0, 6, 32'h40F, 1, 1, 0);
        bus.id_rs2_val = 32'h999;
        step();
        bus.id_valid = 0;
        bus.mem_we = 1; bus.mem_rd = 0; bus.mem_val = 32'hFFFF;
        #1 chk("srai_b", bus.ex_b, 32'h40F);
        chk("srai_shamt", 32'(bus.ex_shamt), 15);
        chk("srai_store", bus.ex_store_val, 0);
        step();
        bus.mem_we = 0;

        // flush and hazard in the same cycle
        set_id(ALU_ADD, 1, 0, 3, 32'd0, 1, 1, 1);
        step();
        bc = bus.bubble_cnt;
        set_id(ALU_SLL, 3, 3, 4, 32'd0, 0, 1, 0);
        bus.flush = 1;
        #1 chk("fh_stall", 32'(bus.stall), 1);
        step();
        bus.flush = 0;
        chk("fh_valid", 32'(bus.ex_valid), 0);
        chk("fh_bubble", bus.bubble_cnt, bc);

        // reset asserted during a hazard
        set_id(ALU_ADD, 1, 0, 3, 32'd0, 1, 1, 1);
        step();
        set_id(ALU_SLL, 2, 3, 4, 32'd0, 0, 1, 0);
        rst = 1;
        step();
        rst = 0;
        chk("rh_valid", 32'(bus.ex_valid), 0);
        chk("rh_stall", 32'(bus.stall), 0);
        chk("rh_bubble", bus.bubble_cnt, 0);
        chk("rh_a", bus.ex_a, 0);
        chk("rh_b", bus.ex_b, 0);
        chk("rh_pc", bus.ex_pc, 0);

        // randomized traffic over a small register window to provoke hazards and forwarding
        for (int i = 0; i < 400; i++) begin
            bus.id_valid   = 1'($urandom_range(0, 3) != 0);
            bus.id_pc      = $urandom;
            bus.id_alu_c   = 5'($urandom_range(0, 13));
            bus.id_rs1     = 5'($urandom_range(0, 3));
            bus.id_rs2     = 5'($urandom_range(0, 3));
            bus.id_rd      = 5'($urandom_range(0, 3));
            bus.id_rs1_val = $urandom;
            bus.id_rs2_val = $urandom;
            bus.id_imm     = $urandom;
            bus.id_use_imm = 1'($urandom_range(0, 1));
            bus.id_we      = 1'($urandom_range(0, 1));
            bus.id_is_load = 1'($urandom_range(0, 2) == 0);
            bus.flush      = 1'($urandom_range(0, 7) == 0);
            bus.mem_rd     = 5'($urandom_range(0, 3));
            bus.mem_we     = 1'($urandom_range(0, 1));
            bus.mem_val    = $urandom;
            bus.wb_rd      = 5'($urandom_range(0, 3));
            bus.wb_we      = 1'($urandom_range(0, 1));
            bus.wb_val     = $urandom;
            rst            = 1'($urandom_range(0, 59) == 0);
            step();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register of the RV32I pipeline; directly upstream of the EX-stage ALU and barrel shifter.
- Latches decoded control (5-bit ALU code per alu.vh), register values, immediate and destination; drives forwarded operands A/B and the 5-bit shift amount to the EX units.
- Detects load-use hazards, inserts bubbles, honours flush, and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width.
- CW, 5, ALU/shift control code width (alu.vh encoding, e.g. ISLL/ISRL/ISRA).
- RW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  XLEN  instruction PC.
- id_alu_c  in  CW  ALU/shift control code.
- id_rs1, id_rs2  in  RW  source indices.
- id_rd  in  RW  destination index.
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_use_imm  in  1  B operand = imm (I-type, incl. slli/srli/srai).
- id_we  in  1  writes rd.
- id_is_load  in  1  load instruction.
- flush  in  1  kill ID/EX contents (taken branch/jump).
- mem_rd  in  RW, mem_we  in  1, mem_val  in  XLEN  EX/MEM forwarding source.
- wb_rd  in  RW, wb_we  in  1, wb_val  in  XLEN  MEM/WB forwarding source.
- stall  out  1  hold PC and IF/ID (combinational).
- ex_valid  out  1  EX slot valid.
- ex_pc  out  XLEN, ex_alu_c  out  CW, ex_rd  out  RW, ex_we  out  1, ex_is_load  out  1  registered fields.
- ex_a, ex_b  out  XLEN  forwarded ALU operands.
- ex_shamt  out  5  ex_b[4:0], to shifter B.
- ex_store_val  out  XLEN  forwarded rs2 (store data).
- bubble_cnt  out  32  bubbles inserted since reset.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: all registered outputs 0 (ex_valid=0, ex_alu_c=0, ex_we=0, ex_is_load=0, bubble_cnt=0). stall=0 while ex_valid=0.
- Hazard (combinational): hz = id_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). stall = hz.
- Register update priority per edge: rst > flush > hz > load.
  - flush: ex_valid<=0, ex_we<=0, ex_is_load<=0; other fields don't-care; no bubble count.
  - hz (no flush): bubble, i.e. ex_valid<=0, ex_we<=0, ex_is_load<=0; bubble_cnt+=1 (wraps at 2^32-1 to 0).
  - else: all id_* latched; ex_valid<=id_valid; ex_we<=id_we&id_valid.
- Flush and hz in the same cycle: flush wins, no count, stall still asserted that cycle (harmless; the front end is also redirected).
- Forwarding (combinational, from registered rs1/rs2):
  - fwd(rs, rf) = (rs==0) ? 0 : (mem_we & mem_rd==rs) ? mem_val : (wb_we & wb_rd==rs) ? wb_val : rf.
  - MEM beats WB. x0 is never forwarded and always reads 0.
- Operand outputs: ex_a = fwd(rs1); ex_store_val = fwd(rs2); ex_b = use_imm ? imm : fwd(rs2); ex_shamt = ex_b[4:0].
- Latency: 1 cycle ID→EX; forwarding adds 0 cycles.
- Reset asserted mid-hazard: the next cycle shows ex_valid=0, stall=0 and bubble_cnt=0.

Decomposition:
- Shared package/header (alu.vh extension): CW, RW and XLEN constants, ALU codes, X0 index constant.
- One natural sub-module, fwd_mux: a single-operand forwarding priority mux, instantiated twice (rs1, rs2).

Test Plan:
- Reset then `addi x1,x0,5` (id_alu_c=ADD, imm=5, use_imm=1) → next cycle ex_valid=1, ex_a=0, ex_b=5, ex_rd=1.
- ex holds `lw x3`; ID presents `sll x4,x3,x2` → stall=1, next cycle ex_valid=0, bubble_cnt=1; the following cycle sll latches with stall=0.
- EX holds rs1=7; mem_we=1, mem_rd=7, mem_val=0xAAAA0000 and wb_we=1, wb_rd=7, wb_val=0x1234 → ex_a=0xAAAA0000; drop mem_we → ex_a=0x1234.
- srai with imm=0x40F, rs2=x0, mem_rd=0, mem_we=1, mem_val=0xFFFF → ex_b=0x40F, ex_shamt=15, ex_store_val=0.
- Flush and hazard in the same cycle → ex_valid=0, bubble_cnt unchanged; rst raised during a hazard → all outputs 0 next cycle.
